// File: rtl/hex_display_bank.sv
// hex_display_bank
// ----------------
// Multi-digit seven-segment driver for the DE1-SoC HEX displays. It holds a
// DIGITS-nibble value that is loaded through a valid/ready handshake and
// incremented on command. Each digit is decoded, optionally blanked
// (leading-zero suppression, blinking) and registered onto hex_out.
//
// Parameters:
//   DIGITS   - number of 4-bit digits / displays (1..8)
//   CLK_DIV  - clock cycles per blink half-period (>= 2)
//   BLANK_LZ - 1 = blank leading zero digits, 0 = show every digit
//
// Ports:
//   clock       in   system clock, all state on the rising edge
//   reset       in   synchronous, active-high reset
//   load_valid  in   load request
//   load_data   in   value to load, nibble i drives digit i
//   load_ready  out  a load can be accepted this cycle
//   inc         in   single-cycle increment pulse
//   blink_mask  in   bit i set = digit i blinks
//   hex_out     out  segments, hex_out[7i+6:7i] is digit i, bit0=a..bit6=g,
//                    active-low (0 = lit)
//
// Optional feature: define HEX_DISPLAY_BANK_DECIMAL_EN for BCD mode. inc then
// counts in decimal with per-digit carry, nibbles above 9 are shown blank,
// and an increment treats such a nibble as 9 (rolls to 0 and carries).

module hex_display_bank #(
  parameter int DIGITS   = 6,
  parameter int CLK_DIV  = 25000000,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_valid,
  input  logic [4*DIGITS-1:0]   load_data,
  output logic                  load_ready,
  input  logic                  inc,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [7*DIGITS-1:0]   hex_out
);

  localparam int VW = 4 * DIGITS;
  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(CLK_DIV - 1);

  logic [VW-1:0]         value_reg;
  logic [VW-1:0]         value_next;
  logic [VW-1:0]         value_inc;
  logic [PW-1:0]         prescaler_reg;
  logic                  blink_phase_reg;
  logic [7*DIGITS-1:0]   seg_next;
  logic                  accept;

  // Active-low gfedcba pattern for one hex nibble.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign accept = load_valid & load_ready;

`ifdef HEX_DISPLAY_BANK_DECIMAL_EN
  // Decimal ripple increment. Any nibble >= 9 that receives a carry rolls
  // to 0 and passes the carry on, so out-of-range nibbles behave like 9.
  logic       bcd_carry;
  logic [3:0] bcd_nib;

  always_comb begin
    value_inc = value_reg;
    bcd_carry = 1'b1;
    bcd_nib   = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_nib = value_reg[4*i +: 4];
      if (bcd_carry) begin
        if (bcd_nib >= 4'd9) begin
          value_inc[4*i +: 4] = 4'd0;
        end else begin
          value_inc[4*i +: 4] = bcd_nib + 4'd1;
          bcd_carry = 1'b0;
        end
      end
    end
  end
`else
  // Plain binary increment; all-F wraps naturally to 0.
  always_comb begin
    value_inc = value_reg + VW'(1);
  end
`endif

  // A load beats an increment arriving in the same cycle.
  always_comb begin
    value_next = value_reg;
    if (accept) begin
      value_next = load_data;
    end else if (inc) begin
      value_next = value_inc;
    end
  end

  // Per-digit decode and blanking. The output register samples value_reg,
  // so display trails the value by exactly one edge.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0] nib;
    logic       upper_zero;
    logic       blank_lz;
    logic       blank_blink;
    logic       blank_range;

    assign nib        = value_reg[4*gi +: 4];
    // This digit and every digit above it are zero.
    assign upper_zero = (value_reg[VW-1:4*gi] == '0);
    // Digit 0 is exempt so a zero value still shows a single "0".
    assign blank_lz   = (BLANK_LZ != 0) && (gi != 0) && upper_zero;
    assign blank_blink = blink_mask[gi] & blink_phase_reg;
`ifdef HEX_DISPLAY_BANK_DECIMAL_EN
    assign blank_range = (nib > 4'd9);
`else
    assign blank_range = 1'b0;
`endif

    assign seg_next[7*gi +: 7] = (blank_lz | blank_blink | blank_range)
                               ? 7'b1111111 : seg7(nib);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      value_reg       <= '0;
      hex_out         <= '1;
      load_ready      <= 1'b0;
      prescaler_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else begin
      value_reg  <= value_next;
      hex_out    <= seg_next;
      // Ready drops for one cycle after each accepted load.
      load_ready <= ~accept;
      if (prescaler_reg == PRESCALE_LAST) begin
        prescaler_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        prescaler_reg <= prescaler_reg + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_hex_display_bank.sv
// Testbench for hex_display_bank (DIGITS=4, CLK_DIV=4). A second instance
// with BLANK_LZ=0 shares all inputs. A reference model computes the expected
// outputs from the value, the elapsed cycle count and the segment table, and
// a negedge process compares both instances every cycle. Directed steps also
// check hand-computed literal displays.

module tb_hex_display_bank;

  localparam int DIGITS  = 4;
  localparam int CLK_DIV = 4;
  localparam logic [6:0] BL = 7'h7F;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic                clock;
  logic                reset;
  logic                load_valid;
  logic [4*DIGITS-1:0] load_data;
  logic                load_ready;
  logic                load_ready_nolz;
  logic                inc;
  logic [DIGITS-1:0]   blink_mask;
  logic [7*DIGITS-1:0] hex_out;
  logic [7*DIGITS-1:0] hex_out_nolz;

  int checks = 0;
  int errors = 0;

  hex_display_bank #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BLANK_LZ(1)) dut (
    .clock(clock), .reset(reset), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .inc(inc),
    .blink_mask(blink_mask), .hex_out(hex_out)
  );

  hex_display_bank #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BLANK_LZ(0)) dut_nolz (
    .clock(clock), .reset(reset), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready_nolz), .inc(inc),
    .blink_mask(blink_mask), .hex_out(hex_out_nolz)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] model_inc(input logic [15:0] v);
    logic [15:0] r;
`ifdef HEX_DISPLAY_BANK_DECIMAL_EN
    bit carry;
    int d;
    r = v;
    carry = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'((v >> (4*i)) & 16'hF);
      if (carry) begin
        if (d >= 9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = 4'(d + 1);
          carry = 0;
        end
      end
    end
`else
    r = v + 16'd1;
`endif
    return r;
  endfunction

  function automatic logic [27:0] render(input logic [15:0] v, input logic [3:0] mask,
                                         input int phase, input bit lz);
    logic [27:0] out;
    int nib;
    bit blank;
    out = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = int'((v >> (4*i)) & 16'hF);
      blank = 0;
      if (lz && i > 0 && (v >> (4*i)) == 16'd0) blank = 1;
      if (mask[i] && phase == 1) blank = 1;
`ifdef HEX_DISPLAY_BANK_DECIMAL_EN
      if (nib > 9) blank = 1;
`endif
      out[7*i +: 7] = blank ? BL : SEG_TAB[nib];
    end
    return out;
  endfunction

  logic [15:0] m_value;
  int          m_cnt;
  bit          m_ready;
  logic [27:0] exp_hex;
  logic [27:0] exp_hex_nolz;
  bit          model_valid = 0;

  always @(posedge clock) begin
    bit acc;
    if (reset) begin
      m_value      = 16'd0;
      m_cnt        = 0;
      m_ready      = 0;
      exp_hex      = '1;
      exp_hex_nolz = '1;
    end else begin
      // Blink phase after m_cnt non-reset edges.
      exp_hex      = render(m_value, blink_mask, (m_cnt / CLK_DIV) % 2, 1);
      exp_hex_nolz = render(m_value, blink_mask, (m_cnt / CLK_DIV) % 2, 0);
      acc = load_valid && m_ready;
      if (acc) m_value = load_data;
      else if (inc) m_value = model_inc(m_value);
      m_ready = !acc;
      m_cnt++;
    end
    model_valid = 1;
  end

  always @(negedge clock) begin
    if (model_valid) begin
      check("hex_out", 32'(hex_out), 32'(exp_hex));
      check("hex_out_nolz", 32'(hex_out_nolz), 32'(exp_hex_nolz));
      check("load_ready", 32'(load_ready), 32'(m_ready));
      check("load_ready_nolz", 32'(load_ready_nolz), 32'(m_ready));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [15:0] d);
    load_valid = 1'b1;
    load_data  = d;
    tick();
    load_valid = 1'b0;
  endtask

  logic [6:0] s [16];

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_data = '0; inc = 1'b0; blink_mask = '0;
    repeat (3) tick();
    $display("step reset held: hex_out=%h load_ready=%0d", hex_out, load_ready);
    check("reset_hex", 32'(hex_out), 32'({BL, BL, BL, BL}));
    check("reset_ready", 32'(load_ready), 32'd0);

    reset = 1'b0;
    tick();
    $display("step release: hex_out=%h load_ready=%0d", hex_out, load_ready);
    check("release_ready", 32'(load_ready), 32'd1);
    check("release_hex", 32'(hex_out), 32'({BL, BL, BL, 7'h40}));

    // Load held for two cycles: only the first is accepted.
    load_valid = 1'b1; load_data = 16'h0A3F;
    tick();
    check("load_ready_drop", 32'(load_ready), 32'd0);
    load_data = 16'h1111;
    tick();
    load_valid = 1'b0;
    tick();
    $display("step load 0A3F: hex_out=%h load_ready=%0d", hex_out, load_ready);
`ifdef HEX_DISPLAY_BANK_DECIMAL_EN
    check("load_0a3f", 32'(hex_out), 32'({BL, BL, 7'h30, BL}));
`else
    check("load_0a3f", 32'(hex_out), 32'({BL, 7'h08, 7'h30, 7'h0E}));
`endif
    check("ready_back", 32'(load_ready), 32'd1);

    // FFFF + 1 wraps to 0; inc honoured while ready is low.
    do_load(16'hFFFF);
    inc = 1'b1; tick(); inc = 1'b0;
    tick();
    $display("step FFFF+1: hex_out=%h", hex_out);
    check("wrap_zero", 32'(hex_out), 32'({BL, BL, BL, 7'h40}));

    // Load and inc together: load wins.
    load_valid = 1'b1; load_data = 16'h0005; inc = 1'b1;
    tick();
    load_valid = 1'b0; inc = 1'b0;
    tick();
    $display("step load 0005 with inc: hex_out=%h", hex_out);
    check("load_beats_inc", 32'(hex_out), 32'({BL, BL, BL, 7'h12}));

    // Carry into higher digits.
`ifdef HEX_DISPLAY_BANK_DECIMAL_EN
    do_load(16'h0099);
`else
    do_load(16'h00FF);
`endif
    inc = 1'b1; tick(); inc = 1'b0;
    tick();
    $display("step carry to 100: hex_out=%h", hex_out);
    check("carry_100", 32'(hex_out), 32'({BL, 7'h79, 7'h40, 7'h40}));

    do_load(16'h9999);
    inc = 1'b1; tick(); inc = 1'b0;
    tick();
    $display("step 9999+1: hex_out=%h", hex_out);
`ifdef HEX_DISPLAY_BANK_DECIMAL_EN
    check("inc_9999", 32'(hex_out), 32'({BL, BL, BL, 7'h40}));
`else
    check("inc_9999", 32'(hex_out), 32'({7'h10, 7'h10, 7'h10, 7'h08}));
`endif

    do_load(16'h000C);
    tick();
    $display("step load 000C: hex_out=%h", hex_out);
`ifdef HEX_DISPLAY_BANK_DECIMAL_EN
    check("digit_c", 32'(hex_out), 32'({BL, BL, BL, BL}));
`else
    check("digit_c", 32'(hex_out), 32'({BL, BL, BL, 7'h46}));
`endif

    // Blink digit 0 with value 0012: period 8 edges, so a sample four
    // edges later must be the opposite state.
    blink_mask = 4'b0001;
    do_load(16'h0012);
    tick();
    for (int j = 0; j < 16; j++) begin
      s[j] = hex_out[6:0];
      check("blink_digit1", 32'(hex_out[13:7]), 32'(7'h79));
      check("blink_upper", 32'(hex_out[27:14]), 32'({BL, BL}));
      if (s[j] != 7'h24) check("blink_digit0_set", 32'(s[j]), 32'(BL));
      tick();
    end
    for (int j = 0; j < 12; j++) begin
      checks++;
      if (s[j] == s[j+4]) begin
        errors++;
        $display("FAIL blink_toggle sample%0d=%h sample%0d=%h required different", j, s[j], j+4, s[j+4]);
      end
    end
    $display("step blink: digit0 samples %h %h %h %h", s[0], s[4], s[8], s[12]);
    blink_mask = 4'b0000;

    // No leading-zero blanking on the second instance.
    do_load(16'h0007);
    tick();
    $display("step 0007: hex_out=%h hex_out_nolz=%h", hex_out, hex_out_nolz);
    check("lz_on_7", 32'(hex_out), 32'({BL, BL, BL, 7'h78}));
    check("lz_off_7", 32'(hex_out_nolz), 32'({7'h40, 7'h40, 7'h40, 7'h78}));

    // Reset in the middle of an increment.
    do_load(16'h0A3F);
    inc = 1'b1; reset = 1'b1;
    tick();
    inc = 1'b0;
    $display("step mid reset: hex_out=%h load_ready=%0d", hex_out, load_ready);
    check("midreset_hex", 32'(hex_out), 32'({BL, BL, BL, BL}));
    check("midreset_ready", 32'(load_ready), 32'd0);
    reset = 1'b0;
    tick();
    $display("step after mid reset: hex_out=%h load_ready=%0d", hex_out, load_ready);
    check("after_reset_hex", 32'(hex_out), 32'({BL, BL, BL, 7'h40}));
    check("after_reset_ready", 32'(load_ready), 32'd1);

    repeat (10) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
